controle_jogo_sudoku: RTL and testbench

Game-sequencing controller for the Sudoku datapath. It collects a move from the player's switches and confirm button as row, column, then value. It rejects out-of-range entries and prefilled cells, then drives the move verifier's `enable`. It waits for the verifier's `saidaValor` result code and then either returns to input, declares victory, or ends the game on error. It owns the `regLinha`/`regColuna`/`regValor` registers that feed the verifier, plus the move and error counters shown on the display.

---
 rtl/controle_jogo_sudoku.sv | 228 ++++++++++++++++++++++
 tb/tb_controle_jogo_sudoku.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo_sudoku.sv
// ---------------------------------------------------------------------------
// controle_jogo_sudoku
//
// Game-sequencing controller for the Sudoku datapath. It collects a move
// (row, column, value) from the player's switches and confirm button. It
// rejects out-of-range entries and prefilled cells, then hands the move to
// the verifier and reacts to its result code. It also keeps the move and
// error counters shown on the display.
//
// Parameters
//   TIMEOUT_CICLOS : cycles allowed in VERIFICA_JOGADA before a timeout
//   MAX_ERROS      : errors tolerated before defeat (1..3), used only when
//                    the LIMITE_ERROS_EN macro is defined
//
// Optional feature
//   `define LIMITE_ERROS_EN : allow up to MAX_ERROS invalid moves before
//                             defeat; otherwise the first error ends the game
//
// Ports
//   clk            in  : system clock, rising edge
//   rst            in  : synchronous active-high reset
//   confirma       in  : single-cycle confirm pulse (debounced upstream)
//   entrada[3:0]   in  : player switches
//   posFixa        in  : 1 = cell at regLinha/regColuna is prefilled
//   saidaValor[2:0]in  : verifier result (100 ok, 101 ok+complete, 110 bad)
//   regLinha/regColuna/regValor[3:0] out : move registers, 0 = empty
//   enableVerifica out : verifier enable
//   estado[2:0]    out : current state encoding
//   contJogadas[6:0] out : accepted moves, saturating at 81
//   contErros[1:0] out : invalid moves
//   erroEntrada    out : one-cycle pulse on a rejected entry
//   fimJogo        out : game over
//   venceu         out : game won (valid while fimJogo = 1)
// ---------------------------------------------------------------------------
module controle_jogo_sudoku #(
  parameter int TIMEOUT_CICLOS = 64,
  parameter int MAX_ERROS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirma,
  input  logic [3:0] entrada,
  input  logic       posFixa,
  input  logic [2:0] saidaValor,
  output logic [3:0] regLinha,
  output logic [3:0] regColuna,
  output logic [3:0] regValor,
  output logic       enableVerifica,
  output logic [2:0] estado,
  output logic [6:0] contJogadas,
  output logic [1:0] contErros,
  output logic       erroEntrada,
  output logic       fimJogo,
  output logic       venceu
);

  typedef enum logic [2:0] {
    RECEBE_LINHA    = 3'd0,
    RECEBE_COLUNA   = 3'd1,
    RECEBE_VALOR    = 3'd2,
    VERIFICA_POS    = 3'd3,
    VERIFICA_JOGADA = 3'd4,
    LIBERA          = 3'd5,
    FIM_VITORIA     = 3'd6,
    FIM_DERROTA     = 3'd7
  } estado_t;

  localparam int                WD_W        = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [WD_W-1:0]   WD_ULTIMO   = WD_W'(TIMEOUT_CICLOS - 1);
  localparam logic [6:0]        MAX_JOGADAS = 7'd81;

  // Without the error-limit feature the game behaves as if the limit were
  // one: the first error reaches the defeat compare with contErros = 1.
`ifdef LIMITE_ERROS_EN
  localparam logic [1:0] LIMITE_ERROS = 2'(MAX_ERROS);
`else
  localparam logic [1:0] LIMITE_ERROS = 2'd1;
`endif

  // Registered state and outputs
  estado_t         r_estado;
  logic [3:0]      r_linha, r_coluna, r_valor;
  logic            r_enable, r_erro_entrada, r_fim, r_venceu;
  logic [6:0]      r_cont_jogadas;
  logic [1:0]      r_cont_erros;
  logic [WD_W-1:0] r_watchdog;

  // Next-state values
  estado_t         w_prox;
  logic [3:0]      w_linha, w_coluna, w_valor;
  logic            w_erro_entrada;
  logic [6:0]      w_cont_jogadas;
  logic [1:0]      w_cont_erros;
  logic [WD_W-1:0] w_watchdog;

  // Input decode
  logic       w_entrada_ok;
  logic       w_res_aceita, w_res_vitoria, w_res_invalida, w_timeout;
  logic [6:0] w_jogadas_inc;
  logic [1:0] w_erros_inc;

  assign w_entrada_ok   = (entrada >= 4'd1) && (entrada <= 4'd9);
  // Codes other than 100/101/110 are treated as "busy".
  assign w_res_aceita   = (saidaValor == 3'b100);
  assign w_res_vitoria  = (saidaValor == 3'b101);
  assign w_res_invalida = (saidaValor == 3'b110);
  assign w_timeout      = (r_watchdog == WD_ULTIMO);
  assign w_jogadas_inc  = (r_cont_jogadas == MAX_JOGADAS) ? r_cont_jogadas
                                                          : r_cont_jogadas + 7'd1;
  assign w_erros_inc    = r_cont_erros + 2'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_prox         = r_estado;
    w_linha        = r_linha;
    w_coluna       = r_coluna;
    w_valor        = r_valor;
    w_erro_entrada = 1'b0;
    w_cont_jogadas = r_cont_jogadas;
    w_cont_erros   = r_cont_erros;
    w_watchdog     = '0;

    unique case (r_estado)
      RECEBE_LINHA: if (confirma) begin
        if (w_entrada_ok) begin
          w_linha = entrada;
          w_prox  = RECEBE_COLUNA;
        end else begin
          w_erro_entrada = 1'b1;
        end
      end
      RECEBE_COLUNA: if (confirma) begin
        if (w_entrada_ok) begin
          w_coluna = entrada;
          w_prox   = RECEBE_VALOR;
        end else begin
          w_erro_entrada = 1'b1;
        end
      end
      RECEBE_VALOR: if (confirma) begin
        if (w_entrada_ok) begin
          w_valor = entrada;
          w_prox  = VERIFICA_POS;
        end else begin
          w_erro_entrada = 1'b1;
        end
      end
      VERIFICA_POS: begin
        if (posFixa) begin
          w_erro_entrada = 1'b1;
          w_linha        = 4'd0;
          w_coluna       = 4'd0;
          w_valor        = 4'd0;
          w_prox         = RECEBE_LINHA;
        end else begin
          w_prox = VERIFICA_JOGADA;
        end
      end
      VERIFICA_JOGADA: begin
        // A result arriving in the timeout cycle takes priority.
        if (w_res_aceita) begin
          w_cont_jogadas = w_jogadas_inc;
          w_prox         = LIBERA;
        end else if (w_res_vitoria) begin
          w_cont_jogadas = w_jogadas_inc;
          w_prox         = FIM_VITORIA;
        end else if (w_res_invalida || w_timeout) begin
          w_cont_erros = w_erros_inc;
          w_prox       = (w_erros_inc == LIMITE_ERROS) ? FIM_DERROTA : LIBERA;
        end else begin
          w_watchdog = r_watchdog + 1'b1;
        end
      end
      LIBERA: begin
        w_linha  = 4'd0;
        w_coluna = 4'd0;
        w_valor  = 4'd0;
        w_prox   = RECEBE_LINHA;
      end
      default: ; // FIM_VITORIA / FIM_DERROTA hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst) begin
      r_estado       <= RECEBE_LINHA;
      r_linha        <= 4'd0;
      r_coluna       <= 4'd0;
      r_valor        <= 4'd0;
      r_enable       <= 1'b0;
      r_erro_entrada <= 1'b0;
      r_fim          <= 1'b0;
      r_venceu       <= 1'b0;
      r_cont_jogadas <= 7'd0;
      r_cont_erros   <= 2'd0;
      r_watchdog     <= '0;
    end else begin
      r_estado       <= w_prox;
      r_linha        <= w_linha;
      r_coluna       <= w_coluna;
      r_valor        <= w_valor;
      // Outputs are derived from the next state so they change on the same
      // edge as the state itself.
      r_enable       <= (w_prox == VERIFICA_JOGADA);
      r_erro_entrada <= w_erro_entrada;
      r_fim          <= (w_prox == FIM_VITORIA) || (w_prox == FIM_DERROTA);
      r_venceu       <= (w_prox == FIM_VITORIA);
      r_cont_jogadas <= w_cont_jogadas;
      r_cont_erros   <= w_cont_erros;
      r_watchdog     <= w_watchdog;
    end
  end

  assign estado         = r_estado;
  assign regLinha       = r_linha;
  assign regColuna      = r_coluna;
  assign regValor       = r_valor;
  assign enableVerifica = r_enable;
  assign erroEntrada    = r_erro_entrada;
  assign fimJogo        = r_fim;
  assign venceu         = r_venceu;
  assign contJogadas    = r_cont_jogadas;
  assign contErros      = r_cont_erros;

endmodule

// File: tb/tb_controle_jogo_sudoku.sv
// ---------------------------------------------------------------------------
// tb_controle_jogo_sudoku
//
// Self-checking bench for controle_jogo_sudoku. Moves use random cells,
// verifier delays and "busy" codes; expected counters and destination
// states come from a small game model that applies the game rules directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_controle_jogo_sudoku;

  localparam int TIMEOUT = 64;
  localparam int MAXJ    = 81;
`ifdef LIMITE_ERROS_EN
  localparam int LIMIT = 3;
`else
  localparam int LIMIT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       confirma = 1'b0;
  logic [3:0] entrada = 4'd0;
  logic       posFixa = 1'b0;
  logic [2:0] saidaValor = 3'd0;
  logic [3:0] regLinha, regColuna, regValor;
  logic       enableVerifica, erroEntrada, fimJogo, venceu;
  logic [2:0] estado;
  logic [6:0] contJogadas;
  logic [1:0] contErros;

  int checks = 0;
  int errors = 0;

  // Game model
  int          m_jog = 0;
  int          m_err = 0;
  logic [11:0] m_move = '0;

  always #5 clk = ~clk;

  controle_jogo_sudoku #(.TIMEOUT_CICLOS(TIMEOUT), .MAX_ERROS(3)) dut (
    .clk(clk), .rst(rst), .confirma(confirma), .entrada(entrada),
    .posFixa(posFixa), .saidaValor(saidaValor),
    .regLinha(regLinha), .regColuna(regColuna), .regValor(regValor),
    .enableVerifica(enableVerifica), .estado(estado),
    .contJogadas(contJogadas), .contErros(contErros),
    .erroEntrada(erroEntrada), .fimJogo(fimJogo), .venceu(venceu)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] all_outputs();
    return {regLinha, regColuna, regValor, enableVerifica, estado,
            contJogadas, contErros, erroEntrada, fimJogo, venceu};
  endfunction

  function automatic logic [2:0] busy_code();
    case ($urandom_range(0, 4))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [3:0] bad_entry();
    int r = $urandom_range(0, 6);
    return (r == 0) ? 4'd0 : 4'(r + 9);
  endfunction

  function automatic logic [3:0] good_entry();
    return 4'($urandom_range(1, 9));
  endfunction

  // Apply a verifier outcome to the model; returns the expected next state.
  function automatic int model_outcome(input logic [2:0] code, input bit timed_out);
    if (!timed_out && (code == 3'b100 || code == 3'b101)) begin
      if (m_jog < MAXJ) m_jog++;
      return (code == 3'b101) ? 6 : 5;
    end
    m_err++;
    return (m_err == LIMIT) ? 7 : 5;
  endfunction

  task automatic do_reset();
    rst = 1'b1; confirma = 1'b0; posFixa = 1'b0; saidaValor = busy_code();
    tick();
    rst = 1'b0;
    m_jog = 0; m_err = 0; m_move = '0;
  endtask

  // One confirm pulse; garbage on switches/verifier code between pulses
  // must be ignored by the controller.
  task automatic send(input logic [3:0] v);
    confirma = 1'b1; entrada = v;
    tick();
    confirma = 1'b0; entrada = 4'($urandom); saidaValor = 3'($urandom);
  endtask

  task automatic enter_move(input logic [3:0] l, c, v, input logic pf, input string name);
    posFixa = pf;
    send(l); send(c); send(v);
    m_move = {l, c, v};
    checks++;
    if (estado !== 3'd3 || {regLinha, regColuna, regValor} !== m_move) begin
      errors++;
      $display("FAIL %s entry: estado=%0d regs=%h expected estado=3 regs=%h",
               name, estado, {regLinha, regColuna, regValor}, m_move);
    end
  endtask

  // Called in VERIFICA_POS with posFixa=0. Presents busy codes, then `code`
  // after `delay` cycles in VERIFICA_JOGADA (a busy code means "never").
  task automatic verify(input logic [2:0] code, input int delay, input string name,
                        output int en_cycles);
    bit done = 0;
    bit is_result = (code == 3'b100 || code == 3'b101 || code == 3'b110);
    int exp = 4;
    en_cycles = 0;
    saidaValor = busy_code();
    tick();
    checks++;
    if (estado !== 3'd4 || enableVerifica !== 1'b1 ||
        {regLinha, regColuna, regValor} !== m_move) begin
      errors++;
      $display("FAIL %s enter_vj: estado=%0d en=%0b regs=%h expected 4/1/%h",
               name, estado, enableVerifica, {regLinha, regColuna, regValor}, m_move);
    end
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      if (enableVerifica) en_cycles++;
      saidaValor = (is_result && k == delay) ? code : busy_code();
      tick();
      if (is_result && k == delay) begin
        exp = model_outcome(code, 1'b0); done = 1;
      end else if (k == TIMEOUT - 1) begin
        exp = model_outcome(3'b000, 1'b1); done = 1;
      end
      checks++;
      if (done) begin
        if (estado !== 3'(exp) || contJogadas !== 7'(m_jog) || contErros !== 2'(m_err) ||
            enableVerifica !== 1'b0 || fimJogo !== (exp >= 6) || venceu !== (exp == 6)) begin
          errors++;
          $display("FAIL %s outcome: estado=%0d jog=%0d err=%0d en=%0b fim=%0b win=%0b expected %0d/%0d/%0d/0/%0b/%0b",
                   name, estado, contJogadas, contErros, enableVerifica, fimJogo, venceu,
                   exp, m_jog, m_err, exp >= 6, exp == 6);
        end
      end else if (estado !== 3'd4 || enableVerifica !== 1'b1) begin
        errors++;
        $display("FAIL %s busy k=%0d: estado=%0d en=%0b expected 4/1",
                 name, k, estado, enableVerifica);
      end
    end
    saidaValor = busy_code();
    if (exp == 5) begin
      tick();
      checks++;
      if (estado !== 3'd0 || {regLinha, regColuna, regValor} !== 12'd0 || enableVerifica !== 1'b0) begin
        errors++;
        $display("FAIL %s libera: estado=%0d regs=%h en=%0b expected 0/000/0",
                 name, estado, {regLinha, regColuna, regValor}, enableVerifica);
      end
    end else if (exp >= 6) begin
      checks++;
      if ({regLinha, regColuna, regValor} !== m_move) begin
        errors++;
        $display("FAIL %s hold_regs: regs=%h expected %h",
                 name, {regLinha, regColuna, regValor}, m_move);
      end
    end
  endtask

  task automatic test_reset();
    confirma = 1'b1; entrada = 4'd5;
    tick(); tick();
    do_reset();
    checks++;
    if (all_outputs() !== 28'd0) begin
      errors++;
      $display("FAIL reset: outputs=%h expected 0", all_outputs());
    end
  endtask

  task automatic test_accepted();
    int en;
    do_reset();
    enter_move(4'd3, 4'd5, 4'd7, 1'b0, "accept_fixed");
    verify(3'b100, 2, "accept_fixed", en);
    checks++;
    if (en !== 3) begin
      errors++;
      $display("FAIL accept_fixed enable_cycles: got %0d expected 3", en);
    end
    for (int i = 0; i < 6; i++) begin
      int d = $urandom_range(0, 12);
      enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "accept_rand");
      verify(3'b100, d, "accept_rand", en);
      checks++;
      if (en !== d + 1) begin
        errors++;
        $display("FAIL accept_rand enable_cycles: got %0d expected %0d", en, d + 1);
      end
    end
  endtask

  task automatic test_out_of_range();
    int en;
    do_reset();
    send(4'd0);
    checks++;
    if (erroEntrada !== 1'b1 || estado !== 3'd0 || regLinha !== 4'd0) begin
      errors++;
      $display("FAIL range_zero: err=%0b estado=%0d linha=%0d expected 1/0/0", erroEntrada, estado, regLinha);
    end
    tick();
    checks++;
    if (erroEntrada !== 1'b0) begin
      errors++;
      $display("FAIL range_pulse_width: err=%0b expected 0", erroEntrada);
    end
    send(4'd12);
    checks++;
    if (erroEntrada !== 1'b1 || estado !== 3'd0) begin
      errors++;
      $display("FAIL range_twelve: err=%0b estado=%0d expected 1/0", erroEntrada, estado);
    end
    send(4'd4);
    checks++;
    if (erroEntrada !== 1'b0 || estado !== 3'd1 || regLinha !== 4'd4) begin
      errors++;
      $display("FAIL range_accept_row: err=%0b estado=%0d linha=%0d expected 0/1/4", erroEntrada, estado, regLinha);
    end
    send(bad_entry());
    checks++;
    if (erroEntrada !== 1'b1 || estado !== 3'd1 || regColuna !== 4'd0) begin
      errors++;
      $display("FAIL range_col: err=%0b estado=%0d col=%0d expected 1/1/0", erroEntrada, estado, regColuna);
    end
    send(4'd9);
    send(bad_entry());
    checks++;
    if (erroEntrada !== 1'b1 || estado !== 3'd2 || regValor !== 4'd0) begin
      errors++;
      $display("FAIL range_val: err=%0b estado=%0d val=%0d expected 1/2/0", erroEntrada, estado, regValor);
    end
    posFixa = 1'b0;
    send(4'd1);
    m_move = {4'd4, 4'd9, 4'd1};
    verify(3'b100, $urandom_range(0, 5), "range_move", en);
  endtask

  task automatic test_prefilled();
    enter_move(good_entry(), good_entry(), good_entry(), 1'b1, "prefilled");
    tick();
    checks++;
    if (erroEntrada !== 1'b1 || estado !== 3'd0 || {regLinha, regColuna, regValor} !== 12'd0 ||
        enableVerifica !== 1'b0 || contJogadas !== 7'(m_jog) || contErros !== 2'(m_err)) begin
      errors++;
      $display("FAIL prefilled: err=%0b estado=%0d regs=%h en=%0b jog=%0d errs=%0d expected 1/0/000/0/%0d/%0d",
               erroEntrada, estado, {regLinha, regColuna, regValor}, enableVerifica,
               contJogadas, contErros, m_jog, m_err);
    end
    posFixa = 1'b0;
    tick();
    checks++;
    if (erroEntrada !== 1'b0 || enableVerifica !== 1'b0) begin
      errors++;
      $display("FAIL prefilled_after: err=%0b en=%0b expected 0/0", erroEntrada, enableVerifica);
    end
  endtask

  task automatic test_invalid();
    int en;
    do_reset();
    for (int i = 0; i < LIMIT; i++) begin
      enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "invalid");
      verify(3'b110, $urandom_range(0, 8), "invalid", en);
    end
    checks++;
    if (estado !== 3'd7 || fimJogo !== 1'b1 || venceu !== 1'b0 || contErros !== 2'(LIMIT)) begin
      errors++;
      $display("FAIL invalid_defeat: estado=%0d fim=%0b win=%0b err=%0d expected 7/1/0/%0d",
               estado, fimJogo, venceu, contErros, LIMIT);
    end
    send(good_entry());
    checks++;
    if (estado !== 3'd7 || erroEntrada !== 1'b0 || {regLinha, regColuna, regValor} !== m_move) begin
      errors++;
      $display("FAIL defeat_confirm: estado=%0d err=%0b regs=%h expected 7/0/%h",
               estado, erroEntrada, {regLinha, regColuna, regValor}, m_move);
    end
  endtask

  task automatic test_timeout();
    int en;
    do_reset();
    enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "timeout");
    verify(3'b000, 0, "timeout", en);
    checks++;
    if (en !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout enable_cycles: got %0d expected %0d", en, TIMEOUT);
    end
    do_reset();
    enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "timeout_win");
    verify(3'b101, TIMEOUT - 1, "timeout_win", en);
    checks++;
    if (estado !== 3'd6 || en !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_win: estado=%0d cycles=%0d expected 6/%0d", estado, en, TIMEOUT);
    end
  endtask

  task automatic test_victory_reset();
    int en;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "victory_pre");
      verify(3'b100, $urandom_range(0, 4), "victory_pre", en);
    end
    enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "victory");
    verify(3'b101, $urandom_range(0, 4), "victory", en);
    checks++;
    if (venceu !== 1'b1 || fimJogo !== 1'b1 || contJogadas !== 7'd3) begin
      errors++;
      $display("FAIL victory: win=%0b fim=%0b jog=%0d expected 1/1/3", venceu, fimJogo, contJogadas);
    end
    send(good_entry());
    send(bad_entry());
    checks++;
    if (estado !== 3'd6 || erroEntrada !== 1'b0 || {regLinha, regColuna, regValor} !== m_move) begin
      errors++;
      $display("FAIL victory_confirm: estado=%0d err=%0b regs=%h expected 6/0/%h",
               estado, erroEntrada, {regLinha, regColuna, regValor}, m_move);
    end
    do_reset();
    enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "mid_reset");
    saidaValor = busy_code();
    tick(); tick(); tick();
    checks++;
    if (estado !== 3'd4 || enableVerifica !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: estado=%0d en=%0b expected 4/1", estado, enableVerifica);
    end
    do_reset();
    checks++;
    if (all_outputs() !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset: outputs=%h expected 0", all_outputs());
    end
  endtask

  task automatic test_saturation();
    int en;
    do_reset();
    for (int i = 0; i < MAXJ + 2; i++) begin
      enter_move(good_entry(), good_entry(), good_entry(), 1'b0, "saturate");
      verify(3'b100, 0, "saturate", en);
    end
    checks++;
    if (contJogadas !== 7'd81) begin
      errors++;
      $display("FAIL saturate_final: jog=%0d expected 81", contJogadas);
    end
  endtask

  initial begin
    test_reset();
    test_accepted();
    test_out_of_range();
    test_prefilled();
    test_invalid();
    test_timeout();
    test_victory_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
